// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: default geometry, derived widths and the
// filter FSM state encoding.
package img_pkg;

  localparam int unsigned PX_SIZE      = 8;
  localparam int unsigned IMAGE_WIDTH  = 64;
  localparam int unsigned IMAGE_HEIGHT = 64;

  localparam int unsigned COL_W = $clog2(IMAGE_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMAGE_HEIGHT);

  // Nine PX_SIZE-bit terms need four extra bits.
  localparam int unsigned SUM_W = PX_SIZE + 4;

  typedef enum logic {
    ST_STREAM = 1'b0,
    ST_FLUSH  = 1'b1
  } state_e;

endpackage

// File: rtl/line_buffer.sv
// Fixed-length delay line of Depth advances. It reads before it writes, so
// rd_data_o is the value that was written exactly Depth enabled cycles earlier.
// Storage is never cleared; only the pointer is reset.
module line_buffer #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en_i,
  input  logic [Width-1:0] wr_data_i,
  output logic [Width-1:0] rd_data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  ptr_q;

  // Storage write; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= wr_data_i;
    end
  end

  // Circular pointer, one step per enabled cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  assign rd_data_o = mem_q[ptr_q];

endmodule

// File: rtl/box_filter_3x3.sv
// Streaming 3x3 mean filter. Two chained line buffers plus six window registers
// form the 3x3 neighbourhood around the pixel W+1 slots behind the input. After
// the last input of a frame a W+1-cycle flush pushes zero dummies to drain it.
// Build option: define BOX_BORDER_ZERO_EN to output 0 on border pixels instead
// of passing the centre pixel through.
module box_filter_3x3 #(
  parameter int unsigned PX_SIZE      = img_pkg::PX_SIZE,
  parameter int unsigned IMAGE_WIDTH  = img_pkg::IMAGE_WIDTH,
  parameter int unsigned IMAGE_HEIGHT = img_pkg::IMAGE_HEIGHT
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [PX_SIZE-1:0] input_data,
  input  logic               input_data_valid,
  output logic [PX_SIZE-1:0] output_data,
  output logic               output_data_valid,
  output logic               busy,
  output logic               frame_done
);

  import img_pkg::*;

  localparam int unsigned ColW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned RowW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned FlW  = $clog2(IMAGE_WIDTH + 1);
  localparam int unsigned SumW = PX_SIZE + 4;

  state_e              state_q, state_d;
  logic [FlW-1:0]      flush_cnt_q, flush_cnt_d;
  logic [ColW-1:0]     in_col_q, in_col_d;
  logic [RowW-1:0]     in_row_q, in_row_d;
  logic [ColW-1:0]     out_col_q, out_col_d;
  logic [RowW-1:0]     out_row_q, out_row_d;

  logic                in_acc;
  logic                adv;
  logic                last_in;
  logic                primed;
  logic                emit;
  logic [PX_SIZE-1:0]  pix;
  logic [PX_SIZE-1:0]  lb1_out, lb2_out;

  // Window: b* = current line, m* = one line up, t* = two lines up.
  // Suffix 1 is one slot old, 2 is two slots old; the newest column comes
  // straight from pix / lb1_out / lb2_out.
  logic [PX_SIZE-1:0]  b1_q, b2_q, m1_q, m2_q, t1_q, t2_q;

  logic [SumW-1:0]     sum9;
  logic [SumW-1:0]     quot;
  logic                is_border;
  logic [PX_SIZE-1:0]  border_val;
  logic [PX_SIZE-1:0]  filt;

  logic [PX_SIZE-1:0]  output_data_q;
  logic                output_data_valid_q;
  logic                frame_done_q;

  assign in_acc  = input_data_valid && (state_q == ST_STREAM);
  assign adv     = in_acc || (state_q == ST_FLUSH);
  assign pix     = (state_q == ST_FLUSH) ? '0 : input_data;
  assign last_in = in_acc && (in_col_q == ColW'(IMAGE_WIDTH - 1)) &&
                   (in_row_q == RowW'(IMAGE_HEIGHT - 1));
  // The incoming slot index is at least W+1, so the window is full.
  assign primed  = (in_row_q > RowW'(1)) || ((in_row_q == RowW'(1)) && (in_col_q != '0));
  assign emit    = (in_acc && primed) || (state_q == ST_FLUSH);

  line_buffer #(
    .Width (PX_SIZE),
    .Depth (IMAGE_WIDTH)
  ) u_lb1 (
    .clk       (clk),
    .resetn    (resetn),
    .en_i      (adv),
    .wr_data_i (pix),
    .rd_data_o (lb1_out)
  );

  line_buffer #(
    .Width (PX_SIZE),
    .Depth (IMAGE_WIDTH)
  ) u_lb2 (
    .clk       (clk),
    .resetn    (resetn),
    .en_i      (adv),
    .wr_data_i (lb1_out),
    .rd_data_o (lb2_out)
  );

  // FSM next state and flush cycle counter.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_STREAM: begin
        if (last_in) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FlW'(IMAGE_WIDTH)) begin
          state_d     = ST_STREAM;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_STREAM;
    endcase
  end

  // Input position (real pixels only) and output position (emitted pixels).
  always_comb begin
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    if (in_acc) begin
      if (in_col_q == ColW'(IMAGE_WIDTH - 1)) begin
        in_col_d = '0;
        in_row_d = (in_row_q == RowW'(IMAGE_HEIGHT - 1)) ? '0 : in_row_q + 1'b1;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
    end
    if (emit) begin
      if (out_col_q == ColW'(IMAGE_WIDTH - 1)) begin
        out_col_d = '0;
        out_row_d = (out_row_q == RowW'(IMAGE_HEIGHT - 1)) ? '0 : out_row_q + 1'b1;
      end else begin
        out_col_d = out_col_q + 1'b1;
      end
    end
  end

  // Window sum, constant divide and border selection.
  always_comb begin
    sum9 = SumW'(t2_q) + SumW'(t1_q) + SumW'(lb2_out) +
           SumW'(m2_q) + SumW'(m1_q) + SumW'(lb1_out) +
           SumW'(b2_q) + SumW'(b1_q) + SumW'(pix);
    quot = sum9 / SumW'(9);
    is_border = (out_row_q == '0) || (out_row_q == RowW'(IMAGE_HEIGHT - 1)) ||
                (out_col_q == '0) || (out_col_q == ColW'(IMAGE_WIDTH - 1));
`ifdef BOX_BORDER_ZERO_EN
    border_val = '0;
`else
    border_val = m1_q;
`endif
    filt = is_border ? border_val : quot[PX_SIZE-1:0];
  end

  // State, counters and window shift.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_STREAM;
      flush_cnt_q <= '0;
      in_col_q    <= '0;
      in_row_q    <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      m1_q        <= '0;
      m2_q        <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      if (adv) begin
        b1_q <= pix;
        b2_q <= b1_q;
        m1_q <= lb1_out;
        m2_q <= m1_q;
        t1_q <= lb2_out;
        t2_q <= t1_q;
      end
    end
  end

  // Output register; data holds between valid pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      output_data_q       <= '0;
      output_data_valid_q <= 1'b0;
      frame_done_q        <= 1'b0;
    end else begin
      output_data_valid_q <= emit;
      frame_done_q        <= emit && (out_col_q == ColW'(IMAGE_WIDTH - 1)) &&
                             (out_row_q == RowW'(IMAGE_HEIGHT - 1));
      if (emit) begin
        output_data_q <= filt;
      end
    end
  end

  assign output_data       = output_data_q;
  assign output_data_valid = output_data_valid_q;
  assign frame_done        = frame_done_q;
  assign busy              = (state_q == ST_FLUSH);

endmodule
